// File: rtl/seq_multiplier_if.sv
// Operand/result bundle for the sequential shift-add multiplier.
interface seq_multiplier_if #(
  parameter int unsigned WIDTH = 4
);
  logic                 compute_i;
  logic [WIDTH-1:0]     A_i;
  logic [WIDTH-1:0]     B_i;
  logic [2*WIDTH-1:0]   product_o;
  logic                 busy_o;
  logic                 done_o;

  modport master (
    output compute_i, A_i, B_i,
    input  product_o, busy_o, done_o
  );

  modport slave (
    input  compute_i, A_i, B_i,
    output product_o, busy_o, done_o
  );
endinterface

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier: one iteration per cycle, start on a rising
// edge of compute_i while idle, single-cycle done pulse with the held product.
module seq_multiplier #(
  parameter int unsigned WIDTH = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  seq_multiplier_if.slave bus
);
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             compute_q;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [PW-1:0]    p_q, p_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    product_q, product_d;
  logic             done_q, done_d;
  logic             start_c;
  logic [WIDTH:0]   sum_c;

  // Next-state, datapath and output decode
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done_d    = 1'b0;
    start_c   = bus.compute_i & ~compute_q;
    // Carry-preserving add of the multiplicand into the upper half
    sum_c     = p_q[0] ? ((WIDTH+1)'(p_q[PW-1:WIDTH]) + (WIDTH+1)'(mcand_q))
                       : (WIDTH+1)'(p_q[PW-1:WIDTH]);

    case (state_q)
      IDLE: begin
        if (start_c) begin
          mcand_d = bus.A_i;
          p_d     = {{WIDTH{1'b0}}, bus.B_i};
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        p_d   = PW'({sum_c, p_q[WIDTH-1:0]} >> 1);
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        product_d = p_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // All state, synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      compute_q <= 1'b0;
      mcand_q   <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      compute_q <= bus.compute_i;
      mcand_q   <= mcand_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign bus.product_o = product_q;
  assign bus.done_o    = done_q;
  assign bus.busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier at WIDTH=4.
module tb_seq_multiplier;
  localparam int unsigned WIDTH = 4;

  logic clk_i = 1'b0;
  logic rst_i;
  int   n_checks = 0;
  int   n_fail   = 0;

  seq_multiplier_if #(.WIDTH(WIDTH)) bus ();

  seq_multiplier #(.WIDTH(WIDTH)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start a run (compute_i left high), measure latency and busy span, check result
  task automatic run_mul(input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] exp, input string tag);
    int lat      = 0;
    int busy_cnt = 0;
    bus.A_i       = a;
    bus.B_i       = b;
    bus.compute_i = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.done_o) begin
        lat = i - 1;
        break;
      end
      if (bus.busy_o) busy_cnt++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd5);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd5);
    check({tag, "_product"}, 32'(bus.product_o), 32'(exp));
    tick();
    check({tag, "_done_single"}, 32'(bus.done_o), 32'd0);
    check({tag, "_product_hold"}, 32'(bus.product_o), 32'(exp));
  endtask

  initial begin
    int dones;
    int busies;
    logic [7:0] held;

    rst_i         = 1'b0;
    bus.compute_i = 1'b0;
    bus.A_i       = '0;
    bus.B_i       = '0;
    tick();
    tick();
    check("reset_product", 32'(bus.product_o), 32'd0);
    check("reset_busy", 32'(bus.busy_o), 32'd0);
    check("reset_done", 32'(bus.done_o), 32'd0);
    rst_i = 1'b1;
    tick();

    run_mul(4'd3, 4'd5, 8'd15, "mul_3x5");
    bus.compute_i = 1'b0; tick();
    run_mul(4'd15, 4'd15, 8'd225, "mul_15x15");
    bus.compute_i = 1'b0; tick();
    run_mul(4'd0, 4'd9, 8'd0, "mul_0x9");

    // Level held high: only one run
    bus.compute_i = 1'b0; tick();
    run_mul(4'd2, 4'd3, 8'd6, "mul_2x3");
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.done_o) dones++;
    end
    check("held_extra_done", 32'(dones), 32'd0);
    check("held_product", 32'(bus.product_o), 32'd6);

    // Re-trigger during CALC with new operands is ignored
    bus.compute_i = 1'b0; tick();
    bus.A_i = 4'd3; bus.B_i = 4'd5; bus.compute_i = 1'b1;
    tick(); tick(); tick();
    bus.compute_i = 1'b0; bus.A_i = 4'd7; bus.B_i = 4'd7;
    tick();
    bus.compute_i = 1'b1;
    dones = 0;
    held  = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done_o) begin
        dones++;
        held = bus.product_o;
      end
    end
    check("retrig_done_count", 32'(dones), 32'd1);
    check("retrig_result", 32'(held), 32'd15);
    check("retrig_product_hold", 32'(bus.product_o), 32'd15);

    // Reset mid-CALC aborts the run
    bus.compute_i = 1'b0; tick();
    bus.A_i = 4'd9; bus.B_i = 4'd9; bus.compute_i = 1'b1;
    tick(); tick(); tick();
    rst_i = 1'b0;
    tick();
    check("abort_product", 32'(bus.product_o), 32'd0);
    check("abort_busy", 32'(bus.busy_o), 32'd0);
    check("abort_done", 32'(bus.done_o), 32'd0);
    rst_i = 1'b1; bus.compute_i = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.done_o) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    check("abort_product_after", 32'(bus.product_o), 32'd0);
    run_mul(4'd6, 4'd7, 8'd42, "mul_6x7");

    // compute_i already high at reset release starts a run
    rst_i = 1'b0; bus.compute_i = 1'b1;
    tick();
    rst_i = 1'b1;
    run_mul(4'd4, 4'd4, 8'd16, "rel_start_4x4");

    // Back-to-back with a one-cycle low gap
    bus.compute_i = 1'b0; tick();
    run_mul(4'd13, 4'd11, 8'd143, "b2b_13x11");
    bus.compute_i = 1'b0; tick();
    run_mul(4'd10, 4'd12, 8'd120, "b2b_10x12");

    // Rising edge landing on the DONE cycle is dropped
    bus.compute_i = 1'b0; tick();
    bus.A_i = 4'd2; bus.B_i = 4'd7; bus.compute_i = 1'b1;
    tick();
    bus.compute_i = 1'b0;
    tick(); tick(); tick(); tick();
    bus.compute_i = 1'b1;
    tick();
    check("done_edge_done", 32'(bus.done_o), 32'd1);
    check("done_edge_product", 32'(bus.product_o), 32'd14);
    busies = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.busy_o) busies++;
    end
    check("done_edge_ignored", 32'(busies), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits.
REQ-002 The block SHALL have port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit, the reset: synchronous, active-low, sampled on the rising edge of clk_i.
REQ-004 The block SHALL have port compute_i, input, 1 bit, the start request level from the operand-loading stage; may stay high indefinitely.
REQ-005 The block SHALL have port A_i, input, WIDTH bits, the unsigned multiplicand.
REQ-006 The block SHALL have port B_i, input, WIDTH bits, the unsigned multiplier.
REQ-007 The block SHALL have port product_o, output, 2*WIDTH bits, the last completed unsigned product.
REQ-008 The block SHALL have port busy_o, output, 1 bit, high while a multiplication is in progress.
REQ-009 The block SHALL have port done_o, output, 1 bit, a single-cycle completion pulse.

Function
REQ-010 The block SHALL implement an FSM with states IDLE, CALC and DONE; busy_o SHALL equal (state != IDLE).
REQ-011 The block SHALL register compute_i every cycle (compute_q) and detect start as compute_i=1 AND compute_q=0 in IDLE.
REQ-012 On a start edge (edge 0): capture A_i into the multiplicand register; load the partial-product register P = {WIDTH zeros, B_i}; clear the iteration counter; go IDLE->CALC.
REQ-013 Each CALC edge (edges 1..WIDTH): if P[0]=1, add the multiplicand to P[2W-1:W] with a (WIDTH+1)-bit carry-preserving sum, then shift {carry, P} right by one; counter +1.
REQ-014 At the edge completing iteration WIDTH (edge WIDTH): CALC->DONE.
REQ-015 At edge WIDTH+1 in DONE: product_o <= P, done_o <= 1, DONE->IDLE.
REQ-016 At the next edge (WIDTH+2): done_o <= 0; done_o SHALL never be high for more than one cycle.
REQ-017 Latency from the start edge to done_o high SHALL be WIDTH+1 cycles (5 for WIDTH=4).
REQ-018 product_o SHALL hold its value between DONE states; it SHALL NOT show intermediate P values.
REQ-019 The result SHALL be exact for all operand pairs: (2^WIDTH-1)^2 fits in 2*WIDTH bits; no overflow or truncation.
REQ-020 compute_i held high SHALL start exactly one multiplication; a new run requires compute_i low for at least one cycle, then high.
REQ-021 A rising edge of compute_i while busy_o=1 SHALL be ignored (not queued); compute_q still tracks compute_i.
REQ-022 Changes on A_i or B_i after edge 0 SHALL NOT affect the running computation.
REQ-023 A start edge in the same cycle that DONE returns to IDLE SHALL be ignored: the FSM is in DONE, not IDLE.

Reset
REQ-024 With rst_i=0 at a clock edge, the block SHALL set state=IDLE, product_o=0, done_o=0, busy_o=0, P=0, the multiplicand register to 0, the counter to 0 and compute_q=0.
REQ-025 Reset SHALL override any state, including mid-CALC and DONE. An aborted run SHALL produce no done_o, and product_o SHALL read 0.
REQ-026 With compute_i=1 on the first edge after reset release, a start SHALL be detected, because compute_q resets to 0.

Verification (WIDTH=4)
REQ-027 A_i=3, B_i=5, compute_i 0->1: required response is busy_o high for 5 cycles, done_o high 5 cycles after the start edge, and product_o=15.
REQ-028 A_i=15, B_i=15: required response is product_o=225. A_i=0, B_i=9: required response is product_o=0. Both complete at the same latency.
REQ-029 compute_i held high 30 cycles: required response is exactly one done_o pulse, after which product_o stays constant.
REQ-030 compute_i pulsed low then high at cycle 2 of CALC, with A_i/B_i changed to 7/7 at the same time: required response is that the first result (3x5=15) is unchanged and no second run starts.
REQ-031 rst_i=0 asserted at CALC iteration 2: required response is that all outputs are 0 on the next edge and no done_o occurs. A new start after release (6x7) gives product_o=42.
REQ-032 Back-to-back runs with compute_i toggled low for one cycle after done_o: required response is that both products are correct and each run's done_o is a single cycle.
